// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and fills IF/ID.
// Optional IF_PERF_CNT_EN adds fetch and bubble event counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_inst,
  output logic [31:0] o_ifid_inst,
  output logic [31:0] o_ifid_pc,
  output logic [31:0] o_ifid_pc4,
  output logic        o_ifid_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] o_perf_fetch_cnt,
  output logic [31:0] o_perf_bubble_cnt
`endif
);

  logic [31:0] r_pc;
  logic [31:0] r_ifid_inst;
  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_pc4;
  logic        r_ifid_valid;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;
  logic        w_bubble;
  logic        w_load;

  assign w_pc_plus4 = r_pc + 32'd4;

  // A redirect always squashes the wrong-path fetch and wins over a stall.
  always_comb begin
    w_pc_next = w_pc_plus4;
    w_bubble  = 1'b0;
    w_load    = 1'b0;
    if (i_redirect_valid) begin
      w_pc_next = {i_redirect_pc[31:2], 2'b00};
    end else if (i_stall) begin
      w_pc_next = r_pc;
    end
    if (i_flush || i_redirect_valid) begin
      w_bubble = 1'b1;
    end else if (!i_stall) begin
      w_load = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // Bubbles still record the squashed PC so a waveform shows where fetch was.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ifid_inst  <= NOP_INST;
      r_ifid_pc    <= 32'h0000_0000;
      r_ifid_pc4   <= 32'h0000_0000;
      r_ifid_valid <= 1'b0;
    end else if (w_bubble) begin
      r_ifid_inst  <= NOP_INST;
      r_ifid_pc    <= r_pc;
      r_ifid_pc4   <= w_pc_plus4;
      r_ifid_valid <= 1'b0;
    end else if (w_load) begin
      r_ifid_inst  <= i_imem_inst;
      r_ifid_pc    <= r_pc;
      r_ifid_pc4   <= w_pc_plus4;
      r_ifid_valid <= 1'b1;
    end
  end

  assign o_imem_addr  = r_pc;
  assign o_ifid_inst  = r_ifid_inst;
  assign o_ifid_pc    = r_ifid_pc;
  assign o_ifid_pc4   = r_ifid_pc4;
  assign o_ifid_valid = r_ifid_valid;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetch_cnt;
  logic [31:0] r_perf_bubble_cnt;

  // Every edge is exactly one of: real fetch, or bubble/stall hold.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_perf_fetch_cnt  <= 32'h0000_0000;
      r_perf_bubble_cnt <= 32'h0000_0000;
    end else if (w_load) begin
      r_perf_fetch_cnt  <= r_perf_fetch_cnt + 32'd1;
    end else begin
      r_perf_bubble_cnt <= r_perf_bubble_cnt + 32'd1;
    end
  end

  assign o_perf_fetch_cnt  = r_perf_fetch_cnt;
  assign o_perf_bubble_cnt = r_perf_bubble_cnt;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; memory word k holds 32'h2000_0000 + k.
// Counter checks are compiled in when IF_PERF_CNT_EN is defined.
module tb_if_stage;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic [31:0] imemAddr;
  logic [31:0] imemInst;
  logic [31:0] ifidInst;
  logic [31:0] ifidPc;
  logic [31:0] ifidPc4;
  logic        ifidValid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perfFetchCnt;
  logic [31:0] perfBubbleCnt;
`endif

  int nCompared   = 0;
  int nMismatched = 0;

  if_stage #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(32'h0000_0000)
  ) dut (
    .i_clk            (clock),
    .i_rst            (reset),
    .i_stall          (stall),
    .i_flush          (flush),
    .i_redirect_valid (redirectValid),
    .i_redirect_pc    (redirectPc),
    .o_imem_addr      (imemAddr),
    .i_imem_inst      (imemInst),
    .o_ifid_inst      (ifidInst),
    .o_ifid_pc        (ifidPc),
    .o_ifid_pc4       (ifidPc4),
    .o_ifid_valid     (ifidValid)
`ifdef IF_PERF_CNT_EN
    ,
    .o_perf_fetch_cnt (perfFetchCnt),
    .o_perf_bubble_cnt(perfBubbleCnt)
`endif
  );

  // Zero-latency instruction memory model.
  assign imemInst = 32'h2000_0000 + (imemAddr >> 2);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive the control inputs, then advance one edge and settle past it.
  task automatic applyStimulus(input logic st, input logic fl, input logic rv, input logic [31:0] rpc);
    stall         = st;
    flush         = fl;
    redirectValid = rv;
    redirectPc    = rpc;
    @(posedge clock);
    #1;
    stall         = 1'b0;
    flush         = 1'b0;
    redirectValid = 1'b0;
    redirectPc    = 32'h0;
  endtask

  task automatic checkIfid(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                           input logic valid, input logic [31:0] addr);
    checkOutput({tag, ".ifid_pc"}, ifidPc, pc);
    checkOutput({tag, ".ifid_pc4"}, ifidPc4, pc + 32'd4);
    checkOutput({tag, ".ifid_inst"}, ifidInst, inst);
    checkOutput({tag, ".ifid_valid"}, {31'b0, ifidValid}, {31'b0, valid});
    checkOutput({tag, ".imem_addr"}, imemAddr, addr);
  endtask

  task automatic doReset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clock);
    #1;
    checkOutput("rst.imem_addr", imemAddr, 32'h0);
    checkOutput("rst.ifid_inst", ifidInst, 32'h0);
    checkOutput("rst.ifid_pc", ifidPc, 32'h0);
    checkOutput("rst.ifid_pc4", ifidPc4, 32'h0);
    checkOutput("rst.ifid_valid", {31'b0, ifidValid}, 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    stall         = 1'b0;
    flush         = 1'b0;
    redirectValid = 1'b0;
    redirectPc    = 32'h0;
    reset         = 1'b1;

    // Reset sequencing and straight-line fetch.
    doReset(3);
    applyStimulus(0, 0, 0, 0); checkIfid("seq0", 32'h0,  32'h2000_0000, 1, 32'h4);
    applyStimulus(0, 0, 0, 0); checkIfid("seq1", 32'h4,  32'h2000_0001, 1, 32'h8);
    applyStimulus(0, 0, 0, 0); checkIfid("seq2", 32'h8,  32'h2000_0002, 1, 32'hC);
    applyStimulus(0, 0, 0, 0); checkIfid("seq3", 32'hC,  32'h2000_0003, 1, 32'h10);

    // Stall for two cycles while pc=8.
    doReset(1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0); checkIfid("pre",   32'h4, 32'h2000_0001, 1, 32'h8);
    applyStimulus(1, 0, 0, 0); checkIfid("stl0",  32'h4, 32'h2000_0001, 1, 32'h8);
    applyStimulus(1, 0, 0, 0); checkIfid("stl1",  32'h4, 32'h2000_0001, 1, 32'h8);
    applyStimulus(0, 0, 0, 0); checkIfid("post0", 32'h8, 32'h2000_0002, 1, 32'hC);
    applyStimulus(0, 0, 0, 0); checkIfid("post1", 32'hC, 32'h2000_0003, 1, 32'h10);

    // Redirect with flush at pc=16.
    applyStimulus(0, 1, 1, 32'h40); checkIfid("rdf0", 32'h10, 32'h0, 0, 32'h40);
    applyStimulus(0, 0, 0, 0);      checkIfid("rdf1", 32'h40, 32'h2000_0010, 1, 32'h44);

    // Redirect beats stall, misaligned target.
    applyStimulus(1, 0, 1, 32'h83); checkIfid("rds0", 32'h44, 32'h0, 0, 32'h80);
    applyStimulus(0, 0, 0, 0);      checkIfid("rds1", 32'h80, 32'h2000_0020, 1, 32'h84);

    // Back-to-back redirects: the last one wins.
    applyStimulus(0, 0, 1, 32'h100); checkIfid("rr0", 32'h84,  32'h0, 0, 32'h100);
    applyStimulus(0, 0, 1, 32'h200); checkIfid("rr1", 32'h100, 32'h0, 0, 32'h200);
    applyStimulus(0, 0, 0, 0);       checkIfid("rr2", 32'h200, 32'h2000_0080, 1, 32'h204);

    // Flush with stall and no redirect: bubble, PC holds.
    applyStimulus(1, 1, 0, 0); checkIfid("fs0", 32'h204, 32'h0, 0, 32'h204);
    applyStimulus(0, 0, 0, 0); checkIfid("fs1", 32'h204, 32'h2000_0081, 1, 32'h208);

    // PC wrap at the top of the address space.
    applyStimulus(0, 0, 1, 32'hFFFF_FFFC); checkIfid("wr0", 32'h208, 32'h0, 0, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 0);
    checkOutput("wr1.imem_addr", imemAddr, 32'h0);
    checkOutput("wr1.ifid_pc", ifidPc, 32'hFFFF_FFFC);
    checkOutput("wr1.ifid_pc4", ifidPc4, 32'h0);
    checkOutput("wr1.ifid_inst", ifidInst, 32'h5FFF_FFFF);
    checkOutput("wr1.ifid_valid", {31'b0, ifidValid}, 32'h1);

    // Asynchronous reset mid-cycle, observed before the next edge.
    applyStimulus(0, 0, 0, 0);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("arst.imem_addr", imemAddr, 32'h0);
    checkOutput("arst.ifid_valid", {31'b0, ifidValid}, 32'h0);
    checkOutput("arst.ifid_inst", ifidInst, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0); checkIfid("arst1", 32'h0, 32'h2000_0000, 1, 32'h4);

`ifdef IF_PERF_CNT_EN
    // Counters: ten fetches, three stall holds, one flush bubble.
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("perf.rst_fetch", perfFetchCnt, 32'd0);
    checkOutput("perf.rst_bubble", perfBubbleCnt, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("perf.fetch", perfFetchCnt, 32'd10);
    checkOutput("perf.bubble", perfBubbleCnt, 32'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined MIPS core.
- Owns the program counter and drives the instruction memory read address.
- Captures the returned instruction, PC and PC+4 into the IF/ID pipeline register.
- Supports load-use stall, branch/jump redirect and pipeline flush from downstream stages.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word (sll $0,$0,0) inserted into IF/ID on a bubble.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hazard unit: hold PC and IF/ID contents.
- flush  input  1  squash the IF/ID register (bubble).
- redirect_valid  input  1  load PC from redirect_pc (taken branch, jump, jr).
- redirect_pc  input  32  redirect target.
- imem_addr  output  32  read address to instruction memory; equals the current PC.
- imem_inst  input  32  instruction returned combinationally for imem_addr.
- ifid_inst  output  32  registered instruction.
- ifid_pc  output  32  registered PC of ifid_inst.
- ifid_pc4  output  32  registered ifid_pc + 4.
- ifid_valid  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async assert, effective immediately, also mid-operation):
  - pc = RESET_PC
  - ifid_inst = NOP_INST
  - ifid_pc = 0
  - ifid_pc4 = 0
  - ifid_valid = 0
  - Release takes effect at the next rising edge after rst deasserts.
- imem_addr = pc combinationally. Memory read is zero-latency, so imem_inst is sampled in the same cycle.
- pc_plus4 = pc + 32'd4, modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
- PC update per clock, priority high to low:
  1. redirect_valid: pc <= {redirect_pc[31:2], 2'b00}. Low bits are forced to zero; this overrides stall.
  2. stall: pc holds.
  3. Otherwise: pc <= pc_plus4.
- IF/ID update per clock, priority high to low:
  1. flush or redirect_valid: bubble.
     - ifid_inst <= NOP_INST, ifid_valid <= 0.
     - ifid_pc and ifid_pc4 <= current pc and pc_plus4 (debug only).
  2. stall: all IF/ID fields hold, including ifid_valid.
  3. Otherwise: ifid_inst <= imem_inst, ifid_pc <= pc, ifid_pc4 <= pc_plus4, ifid_valid <= 1.
- Simultaneous events:
  - flush+stall without redirect: IF/ID becomes a bubble, PC holds.
  - redirect+stall: PC loads the target, IF/ID becomes a bubble.
  - Repeated redirects in consecutive cycles: each one is honoured; the last one wins.
- First instruction: at the first edge after reset release, IF/ID captures mem[RESET_PC] with ifid_valid=1, provided there is no stall or flush.
- Latency: PC to IF/ID is one cycle; redirect to the target instruction in IF/ID is two edges.
- No combinational path from any input to any output except imem_inst to nothing (imem_inst is registered). imem_addr depends on state only.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined, the block adds two outputs:
  - perf_fetch_cnt  output 32: increments on each edge where IF/ID loads a valid instruction (case 3 above).
  - perf_bubble_cnt  output 32: increments on each edge where IF/ID loads a bubble or holds due to stall.
  - Both reset to 0, wrap modulo 2^32, and never increment in the same cycle.
- When undefined, the counters and ports are absent; all other behaviour is identical.

Test Plan:
- Reset sequencing:
  - Stimulus: RESET_PC=0, memory loaded with word k = 32'h2000_0000+k; hold rst 3 cycles, release, run 4 cycles.
  - Required response: ifid_pc = 0,4,8,12; ifid_inst = 32'h2000_0000..3; ifid_valid=1; imem_addr leads ifid_pc by 4.
- Stall:
  - Stimulus: assert stall 2 cycles while pc=8.
  - Required response: imem_addr stays 8, IF/ID holds pc=4 for 2 cycles; after release, ifid_pc=8, then 12.
- Redirect and flush:
  - Stimulus: redirect_valid=1, redirect_pc=32'h40, flush=1 for one cycle at pc=16.
  - Required response: next cycle ifid_valid=0, ifid_inst=NOP_INST, imem_addr=32'h40; following cycle ifid_pc=32'h40, ifid_valid=1.
- Redirect beats stall, misaligned target:
  - Stimulus: redirect_valid=1 and stall=1 together, redirect_pc=32'h83.
  - Required response: pc=32'h80, bubble in IF/ID.
- Wrap and async reset:
  - Stimulus: force pc to 32'hFFFF_FFFC by redirect; run one cycle, then assert rst mid-cycle.
  - Required response: imem_addr=0 after the wrap; rst assertion clears ifid_valid and sets imem_addr=RESET_PC before the next edge.
- With IF_PERF_CNT_EN:
  - Stimulus: 10 normal cycles, 3 stall cycles, 1 flush.
  - Required response: perf_fetch_cnt=10, perf_bubble_cnt=4.
